// File: rtl/eth_pkg.sv
// Shared types for the Ethernet TX DMA: opcodes, status encoding, the minimum frame size,
// and a reduced uncached BedRock memory message layout used on the I/O port.
package eth_pkg;

  localparam int paddr_width_gp     = 40;
  localparam int lce_id_width_gp    = 4;
  localparam int dword_width_gp     = 64;
  localparam int min_frame_bytes_gp = 60;

  typedef enum logic [2:0] {
    e_eth_tx_set_len = 3'b100,
    e_eth_tx_start   = 3'b101
  } eth_cmd_e;

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_busy  = 2'd1,
    e_done  = 2'd2,
    e_error = 2'd3
  } eth_tx_state_e;

  typedef enum logic [3:0] {
    e_bedrock_mem_uc_rd = 4'b0000,
    e_bedrock_mem_uc_wr = 4'b0001
  } bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_8 = 3'b011
  } bedrock_msg_size_e;

  typedef struct packed {
    logic [lce_id_width_gp-1:0] lce_id;
  } bedrock_payload_s;

  typedef struct packed {
    bedrock_payload_s          payload;
    bedrock_msg_size_e         size;
    logic [paddr_width_gp-1:0] addr;
    bedrock_mem_type_e         msg_type;
  } bedrock_mem_header_s;

  typedef struct packed {
    logic [dword_width_gp-1:0] data;
    bedrock_mem_header_s       header;
  } cce_mem_msg_s;

  localparam int cce_mem_msg_width_gp = $bits(cce_mem_msg_s);
  localparam logic [2:0] min_frame_rem_gp = 3'(min_frame_bytes_gp % 8);

  // Byte enables for a beat carrying rem valid bytes (rem==0 means a full beat).
  function automatic logic [7:0] keep_mask(input logic [2:0] rem);
    return (rem == 3'd0) ? 8'hFF : 8'((9'd1 << rem) - 9'd1);
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small 1-read/1-write FIFO with valid/ready input and valid/yumi output; no bypass,
// so data written in cycle M is visible at the head in M+1.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 64,
  parameter int els_p   = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);
  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;

  logic [width_p-1:0] mem_r [els_p];
  logic [ptr_w-1:0]   rptr_r, wptr_r;
  logic [ptr_w:0]     cnt_r;
  logic               enq, deq;

  assign ready_o = (cnt_r != (ptr_w+1)'(els_p));
  assign v_o     = (cnt_r != '0);
  assign data_o  = mem_r[rptr_r];
  assign enq     = v_i && ready_o;
  assign deq     = yumi_i && v_o;

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_r <= '0;
      wptr_r <= '0;
      cnt_r  <= '0;
    end else begin
      if (enq) wptr_r <= (wptr_r == ptr_w'(els_p-1)) ? '0 : wptr_r + 1'b1;
      if (deq) rptr_r <= (rptr_r == ptr_w'(els_p-1)) ? '0 : rptr_r + 1'b1;
      case ({enq, deq})
        2'b10:   cnt_r <= cnt_r + 1'b1;
        2'b01:   cnt_r <= cnt_r - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/eth_tx_dma.sv
// Ethernet TX DMA: fetches a frame with uncached 8-byte reads and streams it onto TX AXIS.
// Optional ETH_TX_DMA_PAD_EN zero-pads short frames to the minimum size locally.
module eth_tx_dma
  import eth_pkg::*;
#(
  parameter int axis_data_width_p = 64,
  parameter int eth_cmd_width_p   = 3,
  parameter int max_credits_p     = 8,
  parameter int max_len_p         = 1536
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [lce_id_width_gp-1:0]      lce_id_i,
  input  logic [eth_cmd_width_p-1:0]      eth_cmd_i,
  input  logic                            eth_cmd_v_i,
  input  logic [paddr_width_gp-1:0]       eth_cmd_arg_i,
  output logic [cce_mem_msg_width_gp-1:0] io_cmd_o,
  output logic                            io_cmd_v_o,
  input  logic                            io_cmd_yumi_i,
  input  logic [cce_mem_msg_width_gp-1:0] io_resp_i,
  input  logic                            io_resp_v_i,
  output logic                            io_resp_ready_o,
  output logic [axis_data_width_p-1:0]    tx_axis_tdata_o,
  output logic [7:0]                      tx_axis_tkeep_o,
  output logic                            tx_axis_tvalid_o,
  input  logic                            tx_axis_tready_i,
  output logic                            tx_axis_tlast_o,
  output logic                            tx_axis_tuser_o,
  output logic [1:0]                      tx_ext_state_o
);
  localparam int         cred_w       = $clog2(max_credits_p + 1);
  localparam logic [cred_w-1:0] cred_max_lp = cred_w'(max_credits_p);
  localparam logic [10:0] max_len_lp  = 11'(max_len_p);

  eth_tx_state_e              state_r, state_n;
  logic [10:0]                len_r;
  logic [paddr_width_gp-1:0]  addr_r;
  logic [8:0]                 issued_r, sent_r, rd_beats, tx_beats;
  logic [11:0]                len_p7;
  logic [cred_w-1:0]          credits_r;
  logic                       cmd_ok, set_len, start, len_bad, busy, pad_on;
  logic                       cmd_hs, beat_hs, mem_beat, mem_pop, last_beat;
  logic                       fifo_v;
  logic [dword_width_gp-1:0]  fifo_data;
  logic [7:0]                 data_mask;
  cce_mem_msg_s               cmd_msg, resp_msg;
  logic                       unused_resp_hdr;

  assign cmd_ok  = eth_cmd_v_i && (state_r != e_busy);
  assign set_len = cmd_ok && (eth_cmd_i == e_eth_tx_set_len);
  assign start   = cmd_ok && (eth_cmd_i == e_eth_tx_start);
  assign len_bad = (len_r == '0) || (len_r > max_len_lp);

  assign len_p7   = {1'b0, len_r} + 12'd7;
  assign rd_beats = len_p7[11:3];

`ifdef ETH_TX_DMA_PAD_EN
  localparam logic [8:0] min_beats_lp = 9'((min_frame_bytes_gp + 7) / 8);
  assign pad_on   = (len_r < 11'(min_frame_bytes_gp));
  assign tx_beats = pad_on ? min_beats_lp : rd_beats;
`else
  assign pad_on   = 1'b0;
  assign tx_beats = rd_beats;
`endif

  // FSM: state register / next state / outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= e_idle;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    if (start)                                     state_n = len_bad ? e_error : e_busy;
    else if (state_r == e_busy && beat_hs && last_beat) state_n = e_done;
  end

  always_comb begin
    busy           = (state_r == e_busy);
    tx_ext_state_o = state_r;
  end

  // Read issue: one 8-byte uncached read per beat, throttled by credits.
  assign io_cmd_v_o = busy && (issued_r < rd_beats) && (credits_r < cred_max_lp);
  assign cmd_hs     = io_cmd_v_o && io_cmd_yumi_i;

  always_comb begin
    cmd_msg                       = '0;
    cmd_msg.header.msg_type       = e_bedrock_mem_uc_rd;
    cmd_msg.header.size           = e_bedrock_msg_size_8;
    cmd_msg.header.payload.lce_id = lce_id_i;
    cmd_msg.header.addr           = addr_r + {issued_r, 3'b000};
  end
  assign io_cmd_o = cmd_msg;

  assign resp_msg        = io_resp_i;
  assign unused_resp_hdr = ^resp_msg.header;

  bsg_fifo_1r1w_small #(.width_p(dword_width_gp), .els_p(max_credits_p)) resp_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (io_resp_v_i),
    .ready_o (io_resp_ready_o),
    .data_i  (resp_msg.data),
    .v_o     (fifo_v),
    .data_o  (fifo_data),
    .yumi_i  (mem_pop)
  );

  // Beats past the memory-backed part come from a zero source (padding only).
  assign mem_beat         = (sent_r < rd_beats);
  assign tx_axis_tvalid_o = busy && (mem_beat ? fifo_v : 1'b1);
  assign beat_hs          = tx_axis_tvalid_o && tx_axis_tready_i;
  assign mem_pop          = beat_hs && mem_beat;
  assign last_beat        = busy && (sent_r == tx_beats - 9'd1);
  assign tx_axis_tlast_o  = last_beat;
  assign tx_axis_tuser_o  = 1'b0;

  always_comb begin
    tx_axis_tkeep_o = 8'hFF;
    if (last_beat) tx_axis_tkeep_o = pad_on ? keep_mask(min_frame_rem_gp) : keep_mask(len_r[2:0]);
    // When padding, bytes past len in the final memory beat must read as zero.
    data_mask = 8'hFF;
    if (pad_on && sent_r == rd_beats - 9'd1) data_mask = keep_mask(len_r[2:0]);
    tx_axis_tdata_o = '0;
    if (mem_beat)
      for (int b = 0; b < axis_data_width_p/8; b++)
        tx_axis_tdata_o[8*b +: 8] = fifo_data[8*b +: 8] & {8{data_mask[b]}};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      len_r     <= '0;
      addr_r    <= '0;
      issued_r  <= '0;
      sent_r    <= '0;
      credits_r <= '0;
    end else begin
      if (set_len) len_r <= eth_cmd_arg_i[10:0];
      if (start) begin
        addr_r   <= {eth_cmd_arg_i[paddr_width_gp-1:3], 3'b000};
        issued_r <= '0;
        sent_r   <= '0;
      end else begin
        if (cmd_hs)  issued_r <= issued_r + 9'd1;
        if (beat_hs) sent_r   <= sent_r + 9'd1;
      end
      case ({cmd_hs, mem_pop})
        2'b10:   credits_r <= credits_r + 1'b1;
        2'b01:   credits_r <= credits_r - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_dma.sv
// Directed bench for eth_tx_dma: table of frames plus hand sequences for backpressure,
// ignored commands and mid-frame reset; a queue-based memory model answers the reads.
module tb_eth_tx_dma;
  import eth_pkg::*;

  logic clk;
  logic reset;
  logic [lce_id_width_gp-1:0] lce_id;
  logic [2:0] eth_cmd;
  logic eth_cmd_v;
  logic [paddr_width_gp-1:0] eth_cmd_arg;
  logic [cce_mem_msg_width_gp-1:0] io_cmd, io_resp;
  logic io_cmd_v, io_cmd_yumi, io_resp_v, io_resp_ready;
  logic [63:0] tdata;
  logic [7:0] tkeep;
  logic tvalid, tready, tlast, tuser;
  logic [1:0] st;

  eth_tx_dma dut (
    .clk_i(clk), .reset_i(reset), .lce_id_i(lce_id),
    .eth_cmd_i(eth_cmd), .eth_cmd_v_i(eth_cmd_v), .eth_cmd_arg_i(eth_cmd_arg),
    .io_cmd_o(io_cmd), .io_cmd_v_o(io_cmd_v), .io_cmd_yumi_i(io_cmd_yumi),
    .io_resp_i(io_resp), .io_resp_v_i(io_resp_v), .io_resp_ready_o(io_resp_ready),
    .tx_axis_tdata_o(tdata), .tx_axis_tkeep_o(tkeep), .tx_axis_tvalid_o(tvalid),
    .tx_axis_tready_i(tready), .tx_axis_tlast_o(tlast), .tx_axis_tuser_o(tuser),
    .tx_ext_state_o(st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [39:0] addr; int t; } rd_t;
  typedef struct {
    int len; logic [39:0] base; int ymode; int lat; int trm;
    int beats; logic [7:0] keep; logic [1:0] state;
  } vec_t;

  int nc = 0, nf = 0;
  int cyc = 0;
  int yumi_mode, lat_max, tready_mode;
  int cur_rb, outst, max_out, cmd_v_cnt, hdr_bad, blocked;
  rd_t rq[$];
  logic [39:0] cmd_addrs[$];
  logic [63:0] bd[$];
  logic [7:0]  bk[$];
  logic        bl[$];
  int          bc[$];
  vec_t tbl[10];

  function automatic logic [63:0] mem64(input logic [39:0] a);
    return {a[31:0] ^ 32'hDEADBEEF, a[31:0] + 32'h13579BDF};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nc++;
    if (act !== exp) begin
      nf++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cycle: inputs driven and handshakes recorded at the negedge preceding the posedge.
  task automatic tick();
    cce_mem_msg_s c, r;
    @(negedge clk);
    cyc++;
    r = '0;
    io_resp_v = 1'b0;
    if (rq.size() > 0 && rq[0].t <= cyc) begin
      r.data = mem64(rq[0].addr);
      io_resp_v = 1'b1;
    end
    io_resp = r;
    if (io_resp_v && !io_resp_ready) begin
      blocked++; nf++;
      $display("FAIL resp_overflow: ready=%0d, expected 1 at cycle %0d", io_resp_ready, cyc);
    end
    if (io_resp_v && io_resp_ready) void'(rq.pop_front());
    io_cmd_yumi = io_cmd_v && (yumi_mode == 0 || (yumi_mode == 1 && $urandom_range(2) != 0));
    if (io_cmd_v) cmd_v_cnt++;
    if (io_cmd_yumi) begin
      c = io_cmd;
      if (c.header.msg_type != e_bedrock_mem_uc_rd || c.header.size != e_bedrock_msg_size_8 ||
          c.header.payload.lce_id != lce_id || c.data != '0) hdr_bad++;
      cmd_addrs.push_back(c.header.addr);
      rq.push_back('{c.header.addr, cyc + 1 + ((lat_max > 0) ? int'($urandom_range(lat_max)) : 0)});
      outst++;
    end
    tready = (tready_mode == 1) || (tready_mode == 2 && $urandom_range(1) == 1);
    if (tvalid && tready) begin
      if (bd.size() < cur_rb) outst--;
      bd.push_back(tdata); bk.push_back(tkeep); bl.push_back(tlast); bc.push_back(cyc);
    end
    if (outst > max_out) max_out = outst;
  endtask

  task automatic send(input logic [2:0] op, input logic [39:0] arg);
    eth_cmd = op; eth_cmd_arg = arg; eth_cmd_v = 1'b1;
    tick();
    eth_cmd_v = 1'b0;
  endtask

  task automatic begin_frame(input int len, input logic [39:0] base);
    bd.delete(); bk.delete(); bl.delete(); bc.delete(); cmd_addrs.delete();
    cur_rb = (len + 7) / 8; hdr_bad = 0;
    send(3'b100, 40'(len));
    send(3'b101, base);
  endtask

  task automatic wait_done();
    int n = 0;
    while (st == 2'd1 && n < 20000) begin tick(); n++; end
    if (n >= 20000) chk("done_timeout", 64'(n), 64'(0));
    repeat (4) tick();
  endtask

  task automatic check_frame(input int len, input logic [39:0] abase, input int beats,
                             input logic [7:0] keep, input logic [1:0] state);
    int bad_d = 0, bad_a = 0, rb = (len + 7) / 8;
    logic [63:0] e;
    chk("final_state", st, state);
    chk("beat_count", bd.size(), beats);
    chk("read_count", cmd_addrs.size(), (state == 2'd2) ? rb : 0);
    for (int i = 0; i < bd.size(); i++) begin
      e = (i < rb) ? mem64(abase + 40'(8*i)) : 64'h0;
`ifdef ETH_TX_DMA_PAD_EN
      if (len < 60 && i == rb - 1 && len % 8 != 0)
        for (int j = 0; j < 8; j++) if (j >= len % 8) e[8*j +: 8] = 8'h00;
`endif
      if (bd[i] !== e || bl[i] !== (i == beats - 1) || (i != beats - 1 && bk[i] !== 8'hFF)) bad_d++;
    end
    for (int i = 0; i < cmd_addrs.size(); i++)
      if (cmd_addrs[i] !== abase + 40'(8*i)) bad_a++;
    chk("beat_data_order", bad_d, 0);
    chk("read_addrs", bad_a, 0);
    chk("cmd_fields", hdr_bad, 0);
    chk("credits_drained", outst, 0);
    if (bd.size() > 0) chk("last_tkeep", bk[bd.size()-1], keep);
  endtask

  initial begin
    reset = 1'b1; lce_id = 4'h5; eth_cmd = '0; eth_cmd_v = 1'b0; eth_cmd_arg = '0;
    io_cmd_yumi = 1'b0; io_resp_v = 1'b0; io_resp = '0; tready = 1'b0;
    yumi_mode = 0; lat_max = 0; tready_mode = 1;
    cur_rb = 0; outst = 0; max_out = 0; cmd_v_cnt = 0; hdr_bad = 0; blocked = 0;

    tbl[0] = '{64,   40'h80_0000_0100, 0, 0,  1, 8,   8'hFF, 2'd2};
`ifdef ETH_TX_DMA_PAD_EN
    tbl[1] = '{13,   40'h80_0000_0200, 0, 0,  1, 8,   8'h0F, 2'd2};
    tbl[2] = '{8,    40'h80_0000_0280, 0, 2,  1, 8,   8'h0F, 2'd2};
    tbl[3] = '{20,   40'h80_0000_0507, 0, 0,  1, 8,   8'h0F, 2'd2};
`else
    tbl[1] = '{13,   40'h80_0000_0200, 0, 0,  1, 2,   8'h1F, 2'd2};
    tbl[2] = '{8,    40'h80_0000_0280, 0, 2,  1, 1,   8'hFF, 2'd2};
    tbl[3] = '{20,   40'h80_0000_0507, 0, 0,  1, 3,   8'h0F, 2'd2};
`endif
    tbl[4] = '{0,    40'h80_0000_0300, 0, 0,  1, 0,   8'hFF, 2'd3};
    tbl[5] = '{60,   40'h80_0000_0400, 0, 1,  2, 8,   8'h0F, 2'd2};
    tbl[6] = '{1600, 40'h80_0000_0600, 0, 0,  1, 0,   8'hFF, 2'd3};
    tbl[7] = '{1514, 40'h80_0001_0000, 1, 20, 2, 190, 8'h03, 2'd2};
    tbl[8] = '{1537, 40'h80_0000_0700, 0, 0,  1, 0,   8'hFF, 2'd3};
    tbl[9] = '{1536, 40'h80_0002_0008, 0, 3,  1, 192, 8'hFF, 2'd2};

    repeat (3) tick();
    chk("reset_state", st, 2'd0);
    chk("reset_cmd_v", io_cmd_v, 1'b0);
    chk("reset_tvalid", tvalid, 1'b0);
    chk("reset_resp_ready", io_resp_ready, 1'b1);
    chk("tuser_zero", tuser, 1'b0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      yumi_mode = tbl[i].ymode; lat_max = tbl[i].lat; tready_mode = tbl[i].trm;
      begin_frame(tbl[i].len, tbl[i].base);
      chk("state_after_start", st, (tbl[i].state == 2'd3) ? 2'd3 : 2'd1);
      chk("cmd_v_after_start", io_cmd_v, (tbl[i].state == 2'd3) ? 1'b0 : 1'b1);
      wait_done();
      check_frame(tbl[i].len, tbl[i].base & ~40'h7, tbl[i].beats, tbl[i].keep, tbl[i].state);
      if (i == 0 && bc.size() == 8) chk("throughput_1_per_cycle", bc[7] - bc[0], 7);
    end

    // Backpressure: credits cap reads at 8 while tready is low.
    yumi_mode = 0; lat_max = 0; tready_mode = 0;
    begin_frame(128, 40'h80_0000_1000);
    repeat (50) tick();
    chk("bp_outstanding", outst, 8);
    chk("bp_reads_issued", cmd_addrs.size(), 8);
    cmd_v_cnt = 0;
    repeat (10) tick();
    chk("bp_no_cmd_v", cmd_v_cnt, 0);
    tready_mode = 1;
    wait_done();
    check_frame(128, 40'h80_0000_1000, 16, 8'hFF, 2'd2);

    // Commands while busy and unknown opcodes leave the frame alone.
    tready_mode = 0;
    begin_frame(64, 40'h80_0000_2000);
    repeat (5) tick();
    send(3'b100, 40'd16);
    send(3'b101, 40'h90_0000_0000);
    send(3'b001, 40'h0);
    chk("busy_ignores_cmds", st, 2'd1);
    tready_mode = 1;
    wait_done();
    check_frame(64, 40'h80_0000_2000, 8, 8'hFF, 2'd2);
    send(3'b001, 40'h0);
    chk("done_ignores_bad_op", st, 2'd2);

    // Reset mid-frame (no reads outstanding) drops straight to idle.
    yumi_mode = 2;
    begin_frame(64, 40'h80_0000_3000);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("midreset_state", st, 2'd0);
    chk("midreset_cmd_v", io_cmd_v, 1'b0);
    chk("midreset_tvalid", tvalid, 1'b0);
    reset = 1'b0;
    yumi_mode = 0;
    begin_frame(64, 40'h80_0000_3000);
    wait_done();
    check_frame(64, 40'h80_0000_3000, 8, 8'hFF, 2'd2);

    chk("max_outstanding", max_out, 8);
    chk("resp_never_blocked", blocked, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end

endmodule

// File: doc/eth_tx_dma.md
# eth_tx_dma

DMA reader feeding the Ethernet MAC transmit path: on an MMIO command it fetches a frame from memory through the BedRock I/O command/response interface (uncached 8-byte reads), then streams it onto the TX AXI-Stream toward the MAC FIFO. It is the memory-reading, transmitting counterpart of the RX path, which writes received frames to memory. It sits in the BP clock domain between the Ethernet MMIO register block, the I/O network, and the MAC's TX AXIS input.

## Interface
- bp_params_p, e_bp_default_cfg: processor config; supplies paddr_width_p, lce_id_width_p, and the cce_mem_msg widths.
- axis_data_width_p, 64: AXIS beat width; must equal dword_width_gp.
- eth_cmd_width_p, 3: MMIO command opcode width.
- max_credits_p, 8: maximum outstanding reads; also the response buffer depth.
- max_len_p, 1536: maximum frame length in bytes.
- clk_i  in  1  BP clock.
- reset_i  in  1  synchronous, active-high reset.
- lce_id_i  in  lce_id_width_p  source ID placed in the read payload.
- eth_cmd_i  in  eth_cmd_width_p  opcode.
- eth_cmd_v_i  in  1  single-cycle command strobe.
- eth_cmd_arg_i  in  paddr_width_p  argument: length or address.
- io_cmd_o  out  cce_mem_msg_width_lp  read command; the data field is zero.
- io_cmd_v_o  out  1  read command valid.
- io_cmd_yumi_i  in  1  read command consumed.
- io_resp_i  in  cce_mem_msg_width_lp  read response; data[63:0] is used.
- io_resp_v_i  in  1  response valid.
- io_resp_ready_o  out  1  response accepted.
- tx_axis_tdata_o  out  64  TX beat data.
- tx_axis_tkeep_o  out  8  TX byte enables.
- tx_axis_tvalid_o  out  1  TX beat valid.
- tx_axis_tready_i  in  1  TX beat ready.
- tx_axis_tlast_o  out  1  last beat of the frame.
- tx_axis_tuser_o  out  1  always 0.
- tx_ext_state_o  out  2  status: 0 idle, 1 busy, 2 done, 3 error.

## Operation
- Opcodes:
  - e_eth_tx_set_len (3'b100): latches len = arg[10:0]. Accepted in idle, done or error.
  - e_eth_tx_start (3'b101): latches addr = {arg[paddr-1:3], 3'b000}. Accepted in idle, done or error.
  - All other opcodes, and any command while busy: ignored.
- A start with len==0 or len>max_len_p goes to e_error. No reads are issued.
- States and transitions:
  - e_idle → e_busy on a valid start.
  - e_busy → e_done once the beat with tlast has handshaken.
  - e_done and e_error hold until the next valid start.
- Reads:
  - Beat count = ceil(len/8).
  - Command fields: msg_type e_bedrock_mem_uc_rd, size e_bedrock_msg_size_8, payload.lce_id=lce_id_i, addr = addr + 8*issue_idx.
  - io_cmd_v_o is high while issued<beats and credits<max_credits_p.
  - The issue counter advances on io_cmd_yumi_i.
- Credits:
  - +1 on a command yumi; −1 on an AXIS beat handshake.
  - A yumi and a handshake in the same cycle leave the count unchanged.
- Response buffer:
  - bsg FIFO of depth max_credits_p; io_resp_ready_o = FIFO ready.
  - Credits guarantee the FIFO never overflows; the bench must assert on overflow.
- AXIS:
  - tdata = FIFO head; tvalid = FIFO valid.
  - tlast = (sent==beats−1).
  - tkeep = 8'hFF, except on the last beat, where it is (1<<(len%8))−1 when len%8≠0.
- Responses are in order. Response headers are not checked.

## Timing
- Reset values: all valid outputs 0, tx_ext_state_o=0, credits=0, FIFO empty. io_resp_ready_o=1 after reset.
- Start strobe at cycle N: state is busy and io_cmd_v_o=1 at N+1.
- Response handshake at cycle M: the beat is visible on AXIS at M+1 (FIFO, no bypass).
- With tready held high and a zero-latency responder, throughput is 1 beat/cycle.
- Backpressure on tready stalls beats; issue stops when credits=max_credits_p.
- tx_ext_state_o goes to 2 on the cycle after the tlast handshake.
- Reset mid-frame returns to idle immediately. The system must not assert reset while reads are outstanding; late responses are undefined.

## Configuration
- ETH_TX_DMA_PAD_EN defined: frames with len<60 are zero-padded to 60 bytes (8 beats).
  - Padding beats come from a local zero source, not memory reads.
  - The last beat has tkeep=8'h0F.
  - Reads still cover only ceil(len/8) beats.
- ETH_TX_DMA_PAD_EN undefined: frames are sent at the exact len; the MAC pads.

## Structure
- Shared package eth_pkg holds:
  - eth_cmd_e (opcodes).
  - eth_tx_state_e (idle/busy/done/error encoding).
  - The min-frame constant 60.
- One sub-module: response buffer bsg_fifo_1r1w_small (width 64, depth max_credits_p).
- Counters, the FSM, and the tkeep/tlast logic stay in this module.

## Test plan
- len=64, start addr 0x8000_0100, tready=1, zero-latency memory:
  - Expect 8 reads at 0x..100–0x..138.
  - Expect 8 beats, last tkeep=FF with tlast; state=2.
- len=13 with PAD_EN undefined: 2 beats, last tkeep=8'h1F. With PAD_EN defined: 8 beats, beats 2–7 zero, last tkeep=8'h0F.
- tready held 0 for 50 cycles, len=128:
  - Exactly 8 reads outstanding; no further io_cmd_v_o.
  - Resumes on tready; all 16 beats intact and in order.
- len=0 or len=1600 then start: state=3, no io_cmd_v_o. A start after a valid set_len recovers.
- Start while busy, and opcode 3'b001: ignored; the in-flight frame is unchanged.
- Random io_cmd_yumi_i and response delays (0–20 cycles), len=1514:
  - Data matches memory byte-for-byte.
  - Last tkeep=8'h03.
  - Credits never exceed 8.
